acc_datapath: RTL

Parametrised accumulator datapath for the BIP-class processor core, generalising the fixed 16-bit add/sub datapath to a configurable width with an 8-function ALU, registered status flags, and a multi-cycle shift-add multiplier. It sits between the control unit and the data memory. It takes memory read data and the instruction immediate, and returns the accumulator as memory write data. While a multiply runs it raises `Busy` so the control unit stalls.

---
 rtl/acc_datapath_if.sv | 29 ++
 rtl/acc_datapath.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/acc_datapath_if.sv
// Control/data bundle between the control unit (master) and the accumulator
// datapath (slave); signal names match the original flat port list.
interface acc_datapath_if #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 11
);
  logic [1:0]        SelA;
  logic              SelB;
  logic              WrAcc;
  logic [2:0]        Op;
  logic [DATA_W-1:0] Out_Data;
  logic [IMM_W-1:0]  Addr;
  logic [DATA_W-1:0] In_Data;
  logic              Busy;
  logic              Zero;
  logic              Neg;
  logic              Carry;
  logic              Ovf;

  modport master (
    output SelA, SelB, WrAcc, Op, Out_Data, Addr,
    input  In_Data, Busy, Zero, Neg, Carry, Ovf
  );

  modport slave (
    input  SelA, SelB, WrAcc, Op, Out_Data, Addr,
    output In_Data, Busy, Zero, Neg, Carry, Ovf
  );
endinterface

// File: rtl/acc_datapath.sv
// Parametrised accumulator datapath: 8-function ALU, registered flags and a
// DATA_W-cycle shift-add unsigned multiplier that stalls the core via Busy.
module acc_datapath #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 11
) (
  input  logic           clk,
  input  logic           Clear,
  acc_datapath_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int MSB   = DATA_W - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SAR = 3'b110, OP_MUL = 3'b111
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_acc;
  logic                r_z, r_n, r_c, r_v;
  logic [2*DATA_W-1:0] r_mcand, r_prod, w_prod_nxt;
  logic [DATA_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_cnt;

  logic signed [IMM_W-1:0] w_addr_s;
  logic [DATA_W-1:0]   w_imm, w_a, w_b, w_res;
  logic [DATA_W:0]     w_wide;
  logic                w_c, w_v;
  op_e                 w_op;
  logic                w_issue, w_alu_wr, w_mul_start, w_mul_done;

  assign w_addr_s = bus.Addr;
  assign w_imm    = DATA_W'(w_addr_s);
  assign w_a      = r_acc;
  assign w_b      = bus.SelB ? bus.Out_Data : w_imm;
  assign w_op     = op_e'(bus.Op);

  assign w_issue     = (r_state == S_IDLE) && bus.WrAcc;
  assign w_mul_start = w_issue && (bus.SelA == 2'd0) && (w_op == OP_MUL);
  assign w_alu_wr    = w_issue && (bus.SelA == 2'd0) && (w_op != OP_MUL);
  assign w_mul_done  = (r_state == S_MUL) && (r_cnt == CNT_W'(1));
  assign w_prod_nxt  = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  always_comb begin
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_wide = '0;
    unique case (w_op)
      OP_ADD: begin
        w_wide = {1'b0, w_a} + {1'b0, w_b};
        w_res  = w_wide[DATA_W-1:0];
        w_c    = w_wide[DATA_W];
        w_v    = (w_a[MSB] == w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (A < B unsigned).
        w_wide = {1'b0, w_a} - {1'b0, w_b};
        w_res  = w_wide[DATA_W-1:0];
        w_c    = w_wide[DATA_W];
        w_v    = (w_a[MSB] != w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      OP_AND: w_res = w_a & w_b;
      OP_OR:  w_res = w_a | w_b;
      OP_XOR: w_res = w_a ^ w_b;
      OP_SHL: begin
        w_res = {w_a[MSB-1:0], 1'b0};
        w_c   = w_a[MSB];
      end
      OP_SAR: begin
        w_res = {w_a[MSB], w_a[MSB:1]};
        w_c   = w_a[0];
      end
      OP_MUL: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Clear) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_mul_start) w_state_nxt = S_MUL;
      S_MUL:  if (w_mul_done)  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.Busy = (r_state == S_MUL);
  end

  always_ff @(posedge clk) begin
    if (Clear) begin
      r_acc    <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
      if (w_mul_done) begin
        r_acc <= w_prod_nxt[DATA_W-1:0];
        r_z   <= (w_prod_nxt[DATA_W-1:0] == '0);
        r_n   <= w_prod_nxt[MSB];
        r_c   <= 1'b0;
        r_v   <= |w_prod_nxt[2*DATA_W-1:DATA_W];
      end
    end else if (w_mul_start) begin
      r_mcand  <= {{DATA_W{1'b0}}, w_a};
      r_mplier <= w_b;
      r_prod   <= '0;
      r_cnt    <= CNT_W'(DATA_W);
    end else if (w_alu_wr) begin
      r_acc <= w_res;
      r_z   <= (w_res == '0);
      r_n   <= w_res[MSB];
      r_c   <= w_c;
      r_v   <= w_v;
    end else if (w_issue && bus.SelA == 2'd1) begin
      r_acc <= w_imm;
    end else if (w_issue && bus.SelA == 2'd2) begin
      r_acc <= bus.Out_Data;
    end
  end

  assign bus.In_Data = r_acc;
  assign bus.Zero    = r_z;
  assign bus.Neg     = r_n;
  assign bus.Carry   = r_c;
  assign bus.Ovf     = r_v;
endmodule
